pe: RTL and testbench
=====================

Name: pe

Overview:
- Compute-in-memory processing element holding a 64-entry x 4-bit weight store.
- Computes a 64-lane unsigned dot product of stored weights with a 256-bit activation vector, producing a 14-bit partial sum (PSUM).
- Weights are written and read one at a time through a single-port style test/load interface (STDW/STDR/STD_A).
- Sits as one tile in the CIM processor array; the host loads weights, then streams activations.

Parameters:
- N, 64, number of weight/activation lanes (address width = log2(N) = 6).
- WW, 4, weight width in bits, unsigned.
- AW, 4, activation width in bits, unsigned.
- PW, 14, PSUM width; must hold N*(2^WW-1)*(2^AW-1) = 14400.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- STDW  in  1  weight write enable.
- STDR  in  1  weight read enable.
- STD_A  in  6  weight address for write/read.
- weight_in  in  4  write data.
- act_in  in  256  activations; lane i = act_in[4i+3:4i].
- weight_out  out  4  read data.
- PSUM  out  14  registered dot-product result.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All 64 weights cleared to 0.
  - weight_out = 0, PSUM = 0.
  - Reset overrides STDW/STDR.
- Write: at a rising edge with STDW=1, weight[STD_A] <= weight_in. Effective the next cycle.
- Read: at a rising edge with STDR=1 and STDW=0, weight_out <= weight[STD_A].
  - One-cycle latency.
  - weight_out holds its value otherwise.
- Simultaneous STDW=1 and STDR=1: write performed, read ignored, weight_out holds.
- Compute: at every rising edge with STDW=0 and STDR=0, PSUM <= sum over i=0..63 of weight[i]*act_in lane i.
  - Unsigned arithmetic; each product is 8 bits.
  - The sum is computed at full width, so it never overflows 14 bits (max 14400).
  - Uses the weight array contents as of that edge.
- During any cycle with STDW=1 or STDR=1, PSUM holds its previous value.
- Address range 0..63 is the full 6-bit space; there are no out-of-range addresses.
- The weight store is flip-flop based; no external memory macro.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with random inputs -> weight_out=0, PSUM=0. With act_in all ones and STDW=STDR=0 after reset -> PSUM=0 (weights cleared).
- Load: write weight[a] = a mod 16 for a=0..63 (one per cycle, STDW=1, incrementing STD_A with wrap) -> all 64 entries written.
- Readback: STDR=1, STD_A=35 -> next cycle weight_out=3. Also read STD_A=0 -> 0, and STD_A=63 -> 15.
- Dot product: after the load, STDW=STDR=0, act_in = all ones (every lane 15) -> next cycle PSUM = 15*480 = 7200.
- Max/boundary: all weights 15, all activations 15 -> PSUM=14400. All activations 0 -> PSUM=0. Single lane (lane 7 act=1, others 0, weight[7]=9) -> PSUM=9.
- Conflict/hold: STDW=1 and STDR=1 at address 10 with weight_in=5 -> weight[10]=5, weight_out unchanged, PSUM unchanged. Mid-compute reset -> PSUM=0 next cycle.

Source files
------------

// File: rtl/pe.sv
// Compute-in-memory processing element: 64 x 4-bit flip-flop weight store with a
// single-port load/readback path and a registered 64-lane unsigned dot product.
module pe #(
    parameter int N  = 64,
    parameter int WW = 4,
    parameter int AW = 4,
    parameter int PW = 14,
    parameter int AD = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            STDW,
    input  logic            STDR,
    input  logic [AD-1:0]   STD_A,
    input  logic [WW-1:0]   weight_in,
    input  logic [N*AW-1:0] act_in,
    output logic [WW-1:0]   weight_out,
    output logic [PW-1:0]   PSUM
);

    logic [WW-1:0]    weights_q [N];
    logic [WW-1:0]    weights_d [N];
    logic [WW-1:0]    weight_out_q, weight_out_d;
    logic [PW-1:0]    psum_q, psum_d;
    logic [PW-1:0]    dot_sum;
    logic [WW+AW-1:0] prod;

    // Products are zero-extended to full width so the accumulation cannot wrap.
    always_comb begin
        dot_sum = '0;
        prod    = '0;
        for (int i = 0; i < N; i++) begin
            prod    = {{AW{1'b0}}, weights_q[i]} * {{WW{1'b0}}, act_in[i*AW +: AW]};
            dot_sum = dot_sum + {{(PW-WW-AW){1'b0}}, prod};
        end
    end

    // NOTE: every always_comb output gets a hold default first, so no latch is inferred.
    always_comb begin
        weights_d    = weights_q;
        weight_out_d = weight_out_q;
        psum_d       = psum_q;
        if (STDW) begin
            weights_d[STD_A] = weight_in;
        end else if (STDR) begin
            weight_out_d = weights_q[STD_A];
        end else begin
            psum_d = dot_sum;
        end
    end

    // NOTE: the store is plain flops, so clearing it in reset is cheap and well defined.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weights_q    <= '{default: '0};
            weight_out_q <= '0;
            psum_q       <= '0;
        end else begin
            weights_q    <= weights_d;
            weight_out_q <= weight_out_d;
            psum_q       <= psum_d;
        end
    end

    assign weight_out = weight_out_q;
    assign PSUM       = psum_q;

endmodule

// File: tb/tb_pe.sv
// Scoreboard bench for pe: the driver queues hand-computed expectations per cycle,
// a monitor pops and compares them one time unit after each rising edge.
module tb_pe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         STDW = 1'b0;
    logic         STDR = 1'b0;
    logic [5:0]   STD_A = '0;
    logic [3:0]   weight_in = '0;
    logic [255:0] act_in = '0;
    logic [3:0]   weight_out;
    logic [13:0]  PSUM;

    typedef struct {
        logic [3:0]  exp_w;
        logic [13:0] exp_p;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [255:0] ALL15 = {256{1'b1}};
    localparam logic [255:0] ZERO  = '0;

    pe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .STDW      (STDW),
        .STDR      (STDR),
        .STD_A     (STD_A),
        .weight_in (weight_in),
        .act_in    (act_in),
        .weight_out(weight_out),
        .PSUM      (PSUM)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [255:0] lane(input int idx, input logic [3:0] v);
        logic [255:0] a;
        a = '0;
        a[idx*4 +: 4] = v;
        return a;
    endfunction

    // One cycle of stimulus plus the outputs expected after the following rising edge.
    task automatic step(input logic rst, input logic w, input logic r, input logic [5:0] a,
                        input logic [3:0] wi, input logic [255:0] act,
                        input logic [3:0] ew, input logic [13:0] ep, input string name);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        STDW      = w;
        STDR      = r;
        STD_A     = a;
        weight_in = wi;
        act_in    = act;
        e.exp_w   = ew;
        e.exp_p   = ep;
        e.name    = name;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, "/weight_out"}, int'(weight_out), int'(e.exp_w));
                check({e.name, "/PSUM"}, int'(PSUM), int'(e.exp_p));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        // Reset with random inputs on the control and data pins.
        for (int k = 0; k < 2; k++)
            step(1'b0, 1'($urandom), 1'($urandom), 6'($urandom), 4'($urandom),
                 {8{$urandom()}}, 4'd0, 14'd0, "reset");
        step(1'b1, 1'b0, 1'b0, 6'd0, 4'd0, ALL15, 4'd0, 14'd0, "cleared_dot");

        // Load weight[a] = a mod 16; PSUM and weight_out hold.
        for (int a = 0; a < 64; a++)
            step(1'b1, 1'b1, 1'b0, 6'(a), 4'(a % 16), ALL15, 4'd0, 14'd0, "load");

        step(1'b1, 1'b0, 1'b1, 6'd35, 4'd0, ALL15, 4'd3,  14'd0, "read35");
        step(1'b1, 1'b0, 1'b1, 6'd0,  4'd0, ALL15, 4'd0,  14'd0, "read0");
        step(1'b1, 1'b0, 1'b1, 6'd63, 4'd0, ALL15, 4'd15, 14'd0, "read63");

        step(1'b1, 1'b0, 1'b0, 6'd0, 4'd0, ALL15, 4'd15, 14'd7200, "dot_ramp");
        step(1'b1, 1'b0, 1'b0, 6'd0, 4'd0, ZERO,  4'd15, 14'd0,    "dot_zero_act");

        step(1'b1, 1'b1, 1'b0, 6'd7, 4'd9, ZERO, 4'd15, 14'd0, "write7");
        step(1'b1, 1'b0, 1'b0, 6'd0, 4'd0, lane(7, 4'd1), 4'd15, 14'd9, "single_lane7");

        // Simultaneous write and read: write wins, both outputs hold.
        step(1'b1, 1'b1, 1'b1, 6'd10, 4'd5, ALL15, 4'd15, 14'd9, "conflict");
        step(1'b1, 1'b0, 1'b1, 6'd10, 4'd0, ALL15, 4'd5,  14'd9, "read10");
        step(1'b1, 1'b0, 1'b0, 6'd0,  4'd0, lane(10, 4'd2), 4'd5, 14'd10, "lane10");
        step(1'b1, 1'b0, 1'b0, 6'd0,  4'd0, lane(63, 4'd15) | lane(0, 4'd1) | lane(10, 4'd3),
             4'd5, 14'd240, "lanes_0_10_63");

        for (int a = 0; a < 64; a++)
            step(1'b1, 1'b1, 1'b0, 6'(a), 4'd15, ALL15, 4'd5, 14'd240, "load15");
        step(1'b1, 1'b0, 1'b0, 6'd0, 4'd0, ALL15, 4'd5, 14'd14400, "dot_max");
        step(1'b1, 1'b0, 1'b1, 6'd42, 4'd0, ZERO, 4'd15, 14'd14400, "read42");

        // Reset in the middle of computing, then show the store was cleared.
        step(1'b0, 1'b0, 1'b0, 6'd0, 4'd0, ALL15, 4'd0, 14'd0, "mid_reset");
        step(1'b1, 1'b0, 1'b0, 6'd0, 4'd0, ALL15, 4'd0, 14'd0, "post_reset_dot");

        @(posedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
